// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128/192/256 key schedule that streams Nr+1 round keys over valid/ready.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   start, key_in : load a KEY_BITS cipher key (word j = key_in[32j+31:32j]) while idle
//   busy          : high from the accepting edge until the last round key is taken
//   rk_out/rk_idx : round key (column c = bits [32c+31:32c]) and its round number
//   rk_valid/rk_ready : output handshake; done pulses once after the round-Nr transfer
module aes_key_expand #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic [127:0]        rk_out,
  output logic [3:0]          rk_idx,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic                done
);
  localparam int NK = KEY_BITS / 32;
  localparam int NW = 4 * (NK + 7);
  localparam logic [1:0] IDLE = 2'd0, GEN = 2'd1, DRAIN = 2'd2;
  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expand: KEY_BITS must be 128, 192 or 256");
  end
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box = affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y, r;
    y = x;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      y = gmul(y, y);
      r = gmul(r, y);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction
  logic [1:0]  state;
  logic [5:0]  i;
  logic [2:0]  m;
  logic [7:0]  rcon;
  logic [31:0] win [NK];
  logic [95:0] asm_q;
  logic [31:0] prev, sw, w;
  logic        stall;
  assign busy = state != IDLE;
  // win[0] = w[i-Nk], win[NK-1] = w[i-1]; while i < Nk the window rotates the key words through win[0]
  always_comb begin
    prev = win[NK-1];
    sw = sub_word(m == 3'd0 ? {prev[7:0], prev[31:8]} : prev);
    w = i < 6'(NK) ? win[0]
      : m == 3'd0 ? win[0] ^ sw ^ {24'h0, rcon}
      : NK == 8 && m == 3'd4 ? win[0] ^ sw
      : win[0] ^ prev;
    stall = i[1:0] == 2'd3 && rk_valid && !rk_ready;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i <= 6'd0;
      m <= 3'd0;
      rcon <= 8'h00;
      asm_q <= 96'h0;
      rk_out <= 128'h0;
      rk_idx <= 4'd0;
      rk_valid <= 1'b0;
      done <= 1'b0;
      for (int j = 0; j < NK; j++) win[j] <= 32'h0;
    end else begin
      done <= 1'b0;
      if (rk_valid && rk_ready) rk_valid <= 1'b0;
      if (state == IDLE && start) begin
        state <= GEN;
        i <= 6'd0;
        m <= 3'd0;
        rcon <= 8'h01;
        for (int j = 0; j < NK; j++) win[j] <= key_in[32*j +: 32];
      end else if (state == GEN && !stall) begin
        for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
        win[NK-1] <= w;
        asm_q <= {w, asm_q[95:32]};
        i <= i + 6'd1;
        m <= m == 3'(NK - 1) ? 3'd0 : m + 3'd1;
        if (m == 3'd0 && i >= 6'(NK)) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (i[1:0] == 2'd3) begin
          rk_out <= {w, asm_q};
          rk_idx <= i[5:2];
          rk_valid <= 1'b1;
        end
        if (i == 6'(NW - 1)) state <= DRAIN;
      end else if (state == DRAIN && rk_valid && rk_ready) begin
        done <= 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed bench driving 128/192/256-bit instances side by side against a FIPS-197 model
module tb_aes_key_expand;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic st [3];
  logic rdy [3];
  logic bs [3], rkv [3], dn [3];
  logic [127:0] rko [3];
  logic [3:0] rki [3];
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [7:0] sb [256];
  logic [127:0] exp_rk [3][15];
  logic [127:0] got [3][15];
  int n_cmp = 0;
  int n_err = 0;
  aes_key_expand #(.KEY_BITS(128)) u128 (.clk(clk), .rst(rst), .start(st[0]), .key_in(key128), .busy(bs[0]),
    .rk_out(rko[0]), .rk_idx(rki[0]), .rk_valid(rkv[0]), .rk_ready(rdy[0]), .done(dn[0]));
  aes_key_expand #(.KEY_BITS(192)) u192 (.clk(clk), .rst(rst), .start(st[1]), .key_in(key192), .busy(bs[1]),
    .rk_out(rko[1]), .rk_idx(rki[1]), .rk_valid(rkv[1]), .rk_ready(rdy[1]), .done(dn[1]));
  aes_key_expand #(.KEY_BITS(256)) u256 (.clk(clk), .rst(rst), .start(st[2]), .key_in(key256), .busy(bs[2]),
    .rk_out(rko[2]), .rk_idx(rki[2]), .rk_valid(rkv[2]), .rk_ready(rdy[2]), .done(dn[2]));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00;
    aa = a;
    bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox_of(input logic [7:0] x);
    logic [7:0] v, s, c;
    v = 8'h00;
    c = 8'h63;
    for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) v = 8'(y);
    for (int b = 0; b < 8; b++) s[b] = v[b] ^ v[(b+4)%8] ^ v[(b+5)%8] ^ v[(b+6)%8] ^ v[(b+7)%8] ^ c[b];
    return s;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction
  task automatic build(input int s, input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int n = 0; n < 4 * (nr + 1); n++) begin
      if (n < nk) w[n] = key[32*n +: 32];
      else begin
        t = w[n-1];
        if (n % nk == 0) begin
          t = subw({t[7:0], t[31:8]}) ^ {24'h0, rc};
          rc = gm(rc, 8'h02);
        end else if (nk == 8 && n % 8 == 4) t = subw(t);
        w[n] = w[n-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) exp_rk[s][r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask
  task automatic run(input bit rnd, input bit pokes);
    int cnt [3];
    bit pend [3], fin [3], pst [3];
    logic [127:0] pout [3];
    logic [3:0] pidx [3];
    int edges, nr;
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; pend[k] = 0; fin[k] = 0; pst[k] = 0;
      st[k] = 1'b1; rdy[k] = 1'b1;
    end
    @(negedge clk);
    edges = 0;
    while (!(fin[0] && fin[1] && fin[2]) && edges < 400) begin
      for (int k = 0; k < 3; k++) begin
        nr = 10 + 2 * k;
        st[k] = 1'b0;
        if (fin[k]) chk($sformatf("idle_after_done%0d", k), {125'h0, dn[k], rkv[k], bs[k]}, 128'h0);
        else begin
          chk($sformatf("done%0d@%0d", k, edges), {127'h0, dn[k]}, {127'h0, pend[k]});
          chk($sformatf("busy%0d@%0d", k, edges), {127'h0, bs[k]}, {127'h0, !pend[k]});
          if (pst[k]) begin
            chk($sformatf("stall_out%0d@%0d", k, edges), rko[k], pout[k]);
            chk($sformatf("stall_idx%0d@%0d", k, edges), {124'h0, rki[k]}, {124'h0, pidx[k]});
          end
          if (!rnd && rkv[k] === 1'b1) chk($sformatf("valid_time%0d_rk%0d", k, rki[k]), 128'(edges), 128'(4 * (int'(rki[k]) + 1)));
          if (pend[k]) begin
            fin[k] = 1;
            pend[k] = 0;
          end else begin
            if (pokes && edges == 10) st[k] = 1'b1;
            rdy[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pst[k] = rkv[k] && !rdy[k];
            pout[k] = rko[k];
            pidx[k] = rki[k];
            if (rkv[k] && rdy[k]) begin
              if (cnt[k] < 15) begin
                got[k][cnt[k]] = rko[k];
                chk($sformatf("rk%0d_%0d", k, cnt[k]), rko[k], exp_rk[k][cnt[k]]);
              end
              chk($sformatf("idx%0d_%0d", k, cnt[k]), {124'h0, rki[k]}, 128'(cnt[k]));
              if (cnt[k] == nr) begin
                pend[k] = 1;
                if (pokes) st[k] = 1'b1;
              end
              cnt[k]++;
            end
          end
        end
      end
      @(negedge clk);
      edges++;
    end
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0;
      chk($sformatf("finished%0d", k), {127'h0, fin[k]}, 128'h1);
      chk($sformatf("transfers%0d", k), 128'(cnt[k]), 128'(11 + 2 * k));
    end
  endtask
  initial begin
    logic flag;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0;
      rdy[k] = 1'b1;
    end
    key128 = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
    key192 = 192'h7b6b2c52_d2eaf862_e5799080_2bf310c8_52640eda_f7b0738e;
    for (int b = 0; b < 32; b++) key256[8*b +: 8] = 8'(b);
    for (int x = 0; x < 256; x++) sb[x] = sbox_of(8'(x));
    build(0, 4, {128'h0, key128});
    build(1, 6, {64'h0, key192});
    build(2, 8, key256);
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_rk%0d", k), rko[k], 128'h0);
      chk($sformatf("reset_ctl%0d", k), {120'h0, rki[k], rkv[k], dn[k], bs[k], 1'b0}, 128'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 1'b1);
    chk("fips128_rk0", got[0][0], 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b);
    chk("fips128_rk1", got[0][1], 128'h05766c2a_3939a323_b12c5488_17fefaa0);
    chk("fips128_rk10", got[0][10], 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0);
    chk("fips192_rk12", got[1][12], 128'h02220001_0472cc8e_3c778c44_6fa08be9);
    chk("fips256_rk0", got[2][0], 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    chk("fips256_rk14", got[2][14], 128'h36de686d_3cc21a37_e97909bf_cc79fc24);
    repeat (3) @(negedge clk);
    run(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b1;
      rdy[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) st[k] = 1'b0;
    repeat (22) @(negedge clk);
    chk("pre_reset_idx", {124'h0, rki[0]}, 128'h4);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_rk%0d", k), rko[k], 128'h0);
      chk($sformatf("midrst_ctl%0d", k), {120'h0, rki[k], rkv[k], dn[k], bs[k], 1'b0}, 128'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    flag = 1'b0;
    repeat (30) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (rkv[k] !== 1'b0 || bs[k] !== 1'b0) flag = 1'b1;
    end
    chk("quiet_after_reset", {127'h0, flag}, 128'h0);
    run(1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES key-schedule engine generalising the single-round `roundkey` step: it loads a cipher key of KEY_BITS (128/192/256) and streams all Nr+1 round keys, one 128-bit round key per valid/ready transfer, to the pipelined round datapath. It generates one 32-bit schedule word per cycle with an internal FIPS-197 S-box for SubWord. Output backpressure stalls generation without losing words.

## Interface
- KEY_BITS, 128: cipher key size; legal values 128, 192, 256, any other value is an elaboration error. Nk = KEY_BITS/32, Nr = Nk+6.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request expansion; accepted only in IDLE.
- key_in  in  KEY_BITS  cipher key; word j = key_in[32j+31:32j], byte r of word j = bits [32j+8r+7:32j+8r] (FIPS byte 0 in bits [7:0]); sampled only on the accepting edge.
- busy  out  1  high from the accepting edge until the last round key is accepted.
- rk_out  out  128  round key in column-major state packing: byte (r+4c) at bits [8(r+4c)+7:8(r+4c)].
- rk_idx  out  4  round index of rk_out, 0..Nr.
- rk_valid  out  1  rk_out/rk_idx valid.
- rk_ready  in  1  consumer accepts on rk_valid && rk_ready.
- done  out  1  one-cycle pulse on the edge after the round-Nr transfer.

## Operation
- States: IDLE, GEN, DRAIN.
- IDLE: start=1 loads key_in into an Nk-word window, clears word counter i and round counter; goes to GEN. start in GEN/DRAIN is ignored.
- GEN: each non-stalled cycle produces word w[i], i = 0..4(Nr+1)-1:
  - i < Nk: w[i] = key word i.
  - i mod Nk = 0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk].
  - Nk = 8 and i mod 8 = 4: w[i] = w[i-8] ^ SubWord(w[i-1]).
  - otherwise w[i] = w[i-Nk] ^ w[i-1].
  - RotWord moves byte 0 to byte 3; Rcon sequence 01,02,04,08,10,20,40,80,1b,36 in byte 0, other bytes 0.
- Words fill a 4-word assembly register, word c into column c. On the 4th word, the assembly moves to the output register, rk_valid is set, and rk_idx = round count.
- Stall: a cycle that would complete an assembly while rk_valid && !rk_ready freezes i, window and assembly. Simultaneous transfer and completion proceeds without a bubble.
- After word 4(Nr+1)-1, move to DRAIN. On the transfer of rk_idx = Nr: pulse done, drop busy, return to IDLE.
- rk_out/rk_idx stay stable while rk_valid && !rk_ready. rk_valid falls after transfer unless a new key completes on the same edge.

## Timing
- Reset (async, any state): state=IDLE, busy=0, rk_valid=0, done=0, rk_out=0, rk_idx=0, counters=0. Reset mid-expansion discards everything; no partial key appears after release.
- With rk_ready held high, start is accepted at edge E0. rk i becomes valid after edge E0+4(i+1). One round key every 4 cycles.
- Last key appears after 44 / 52 / 60 edges (KEY_BITS 128/192/256). done pulses the edge after its transfer; busy falls on that same edge.
- start asserted on the done edge is ignored; the state is IDLE one cycle later.
- rk_ready low for k cycles over a completed key delays all later keys by k cycles.

## Test plan
- KEY_BITS=128, key_in=128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b, ready=1:
  - rk0 = key_in.
  - rk1 = 128'h05766c2a_3939a323_b12c5488_17fefaa0.
  - rk10 = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0, valid 44 cycles after start.
  - done pulses once.
- KEY_BITS=192, FIPS key 8e73b0f7..522c6b7b packed likewise: rk12 words e98ba06f 448c773c 8ecc7204 01002202; 13 transfers; done pulses once.
- KEY_BITS=256, key 00..1f packed (byte 0 in bits [7:0]): rk0 = 128'h0f0e0d0c_0b0a0908_07060504_03020100, rk14 = 128'h36de686d_3cc21a37_e97909bf_cc79fc24.
- Random rk_ready (~50%): the rk_idx sequence is 0..Nr, gap-free, and values equal the ready=1 run. rk_out is stable while stalled.
- Assert rst mid-GEN at round 5:
  - Outputs go to 0 immediately.
  - After release, no rk_valid appears until a new start.
  - A new start reproduces the full correct sequence.
- start pulsed during GEN and on the done edge: ignored, and the sequence is unaffected.
